// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: splits misaligned RV32 loads/stores into one or two word accesses and merges load data.
module lsu_access_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_func3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_split,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [ADDR_W-1:0] r_addr_b;
    logic [3:0]        r_be_b;
    logic [31:0]       r_wdata_b;
    logic [31:0]       r_a;

    logic [3:0]        w_base;
    logic [7:0]        w_mask;
    logic [63:0]       w_wide;
    logic [ADDR_W-1:0] w_word_a;
    logic [31:0]       w_lo;
    logic [31:0]       w_sh;
    logic [31:0]       w_ext;

    always_comb begin
        w_base   = i_func3[1:0] == 2'd0 ? 4'h1 : i_func3[1:0] == 2'd1 ? 4'h3 : 4'hf;
        w_mask   = {4'h0, w_base} << i_addr[1:0];
        w_wide   = {32'h0, i_wdata} << {i_addr[1:0], 3'b000};
        w_word_a = {i_addr[ADDR_W-1:2], 2'b00};
        // Word B always arrives last, so it is taken straight from the bus.
        w_lo     = r_state == WAIT0 ? i_dmem_rdata : r_a;
        w_sh     = 32'({i_dmem_rdata, w_lo} >> {r_off, 3'b000});
        w_ext    = r_f3[1:0] == 2'd0 ? {{24{~r_f3[2] & w_sh[7]}}, w_sh[7:0]} :
                   r_f3[1:0] == 2'd1 ? {{16{~r_f3[2] & w_sh[15]}}, w_sh[15:0]} : w_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_f3         <= 3'd0;
            r_off        <= 2'd0;
            r_addr_b     <= '0;
            r_be_b       <= 4'h0;
            r_wdata_b    <= 32'h0;
            r_a          <= 32'h0;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_rdata      <= 32'h0;
            o_split      <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'h0;
            o_dmem_wdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_state      <= REQ0;
                    r_we         <= i_req_we;
                    r_f3         <= i_func3;
                    r_off        <= i_addr[1:0];
                    r_addr_b     <= w_word_a + ADDR_W'(4);
                    r_be_b       <= w_mask[7:4];
                    r_wdata_b    <= w_wide[63:32];
                    o_req_ready  <= 1'b0;
                    o_split      <= |w_mask[7:4];
                    o_dmem_req   <= 1'b1;
                    o_dmem_we    <= i_req_we;
                    o_dmem_addr  <= w_word_a;
                    o_dmem_be    <= w_mask[3:0];
                    o_dmem_wdata <= w_wide[31:0];
                end
                REQ0, REQ1: if (i_dmem_gnt) begin
                    if (r_state == REQ0 && o_split) begin
                        o_dmem_addr  <= r_addr_b;
                        o_dmem_be    <= r_be_b;
                        o_dmem_wdata <= r_wdata_b;
                    end
                    if (r_we && r_state == REQ0 && o_split) begin
                        r_state <= REQ1;
                    end else begin
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        if (r_we) begin
                            r_state      <= DONE;
                            o_resp_valid <= 1'b1;
                        end else begin
                            r_state <= r_state == REQ0 ? WAIT0 : WAIT1;
                        end
                    end
                end
                WAIT0: if (i_dmem_rvalid) begin
                    r_a <= i_dmem_rdata;
                    if (o_split) begin
                        r_state    <= REQ1;
                        o_dmem_req <= 1'b1;
                    end else begin
                        r_state      <= DONE;
                        o_resp_valid <= 1'b1;
                        o_rdata      <= w_ext;
                    end
                end
                WAIT1: if (i_dmem_rvalid) begin
                    r_state      <= DONE;
                    o_resp_valid <= 1'b1;
                    o_rdata      <= w_ext;
                end
                DONE: begin
                    r_state      <= IDLE;
                    o_resp_valid <= 1'b0;
                    o_split      <= 1'b0;
                    o_req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_access_sequencer.sv
// tb_lsu_access_sequencer: directed cycle-exact checks of the load/store access sequencer.
module tb_lsu_access_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        split;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    int errors = 0;
    int checks = 0;

    lsu_access_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_func3(func3), .i_addr(addr), .i_wdata(wdata),
        .o_resp_valid(resp_valid), .o_rdata(rdata), .o_split(split),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
        .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_we = we; func3 = f3; addr = a; wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        checks++; if ({resp_valid, split, dmem_req, dmem_we} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {resp_valid, split, dmem_req, dmem_we}); end
        checks++; if (dmem_addr !== 32'h0 || dmem_be !== 4'h0) begin errors++; $display("FAIL rst_addr_be: got %h/%h want 0/0", dmem_addr, dmem_be); end
        checks++; if (dmem_wdata !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0/0", dmem_wdata, rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_aligned;
        dmem_gnt = 1'b1;
        accept(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        checks++; if ({dmem_req, dmem_we, split, resp_valid} !== 4'b1100) begin errors++; $display("FAIL sw_req: got %b want 1100", {dmem_req, dmem_we, split, resp_valid}); end
        checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'hf) begin errors++; $display("FAIL sw_addr_be: got %h/%h want 100/f", dmem_addr, dmem_be); end
        checks++; if (dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
        @(negedge clk);
        checks++; if ({resp_valid, dmem_req} !== 2'b10) begin errors++; $display("FAIL sw_resp: got %b want 10", {resp_valid, dmem_req}); end
        @(negedge clk);
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL sw_idle: got %b want 01", {resp_valid, req_ready}); end
        dmem_gnt = 1'b0;
    endtask

    task automatic test_store_split;
        dmem_gnt = 1'b1;
        accept(1'b1, 3'd1, 32'h103, 32'h0000ABCD);
        checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'h8) begin errors++; $display("FAIL sh0_addr_be: got %h/%h want 100/8", dmem_addr, dmem_be); end
        checks++; if (dmem_wdata[31:24] !== 8'hCD || split !== 1'b1) begin errors++; $display("FAIL sh0_data_split: got %h/%b want cd/1", dmem_wdata[31:24], split); end
        @(negedge clk);
        checks++; if ({dmem_req, dmem_we, split, resp_valid} !== 4'b1110) begin errors++; $display("FAIL sh1_req: got %b want 1110", {dmem_req, dmem_we, split, resp_valid}); end
        checks++; if (dmem_addr !== 32'h104 || dmem_be !== 4'h1) begin errors++; $display("FAIL sh1_addr_be: got %h/%h want 104/1", dmem_addr, dmem_be); end
        checks++; if (dmem_wdata[7:0] !== 8'hAB) begin errors++; $display("FAIL sh1_wdata: got %h want ab", dmem_wdata[7:0]); end
        @(negedge clk);
        checks++; if ({resp_valid, dmem_req} !== 2'b10) begin errors++; $display("FAIL sh_resp: got %b want 10", {resp_valid, dmem_req}); end
        @(negedge clk);
        checks++; if ({resp_valid, split, req_ready} !== 3'b001) begin errors++; $display("FAIL sh_single_resp: got %b want 001", {resp_valid, split, req_ready}); end
        dmem_gnt = 1'b0;
    endtask

    task automatic test_load_split_stall;
        dmem_gnt = 1'b1;
        accept(1'b0, 3'd2, 32'h102, 32'h0);
        checks++; if ({dmem_req, dmem_we, split} !== 3'b101 || dmem_addr !== 32'h100 || dmem_be !== 4'hc) begin errors++; $display("FAIL lw0_req: got %b %h %h want 101 100 c", {dmem_req, dmem_we, split}, dmem_addr, dmem_be); end
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_wait0_req: got %b want 0", dmem_req); end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h104 || dmem_be !== 4'h3) begin errors++; $display("FAIL lw1_req: got %b %h %h want 1 104 3", dmem_req, dmem_addr, dmem_be); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'h104, 4'h3, 32'h0}) begin errors++; $display("FAIL lw1_stall%0d: got %b %h %h %h want 1 104 3 0", i, dmem_req, dmem_addr, dmem_be, dmem_wdata); end
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55667788;
        checks++; if ({resp_valid, dmem_req} !== 2'b00) begin errors++; $display("FAIL lw_wait1: got %b want 00", {resp_valid, dmem_req}); end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'h77881122) begin errors++; $display("FAIL lw_rdata: got %b %h want 1 77881122", resp_valid, rdata); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse: got %b want 0", resp_valid); end
    endtask

    task automatic test_load_half;
        dmem_gnt = 1'b0;
        accept(1'b0, 3'd1, 32'h001, 32'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        checks++; if (dmem_addr !== 32'h0 || dmem_be !== 4'h6 || split !== 1'b0) begin errors++; $display("FAIL lh_req: got %h %h %b want 0 6 0", dmem_addr, dmem_be, split); end
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lh_hold: got %b %b want 1 0", dmem_req, resp_valid); end
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h00800000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'hFFFF8000) begin errors++; $display("FAIL lh_rdata: got %b %h want 1 ffff8000", resp_valid, rdata); end
        @(negedge clk);
        dmem_gnt = 1'b1;
        accept(1'b0, 3'd5, 32'h001, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h00800000;
        checks++; if ({resp_valid, dmem_req, split} !== 3'b000) begin errors++; $display("FAIL lhu_wait: got %b want 000", {resp_valid, dmem_req, split}); end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'h00008000) begin errors++; $display("FAIL lhu_rdata: got %b %h want 1 00008000", resp_valid, rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        dmem_gnt = 1'b1;
        accept(1'b1, 3'd2, 32'h200, 32'h12345678);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'h00008000) begin errors++; $display("FAIL st_keeps_rdata: got %b %h want 1 00008000", resp_valid, rdata); end
        @(negedge clk);
        accept(1'b0, 3'd0, 32'h203, 32'h0);
        checks++; if (dmem_addr !== 32'h200 || dmem_be !== 4'h8 || split !== 1'b0) begin errors++; $display("FAIL lb_req: got %h %h %b want 200 8 0", dmem_addr, dmem_be, split); end
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80000000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %b %h want 1 ffffff80", resp_valid, rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_wait1;
        dmem_gnt = 1'b1;
        accept(1'b0, 3'd2, 32'h102, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h00000001;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        checks++; if ({req_ready, dmem_req, split} !== 3'b100 || rdata !== 32'h0) begin errors++; $display("FAIL rstw1_state: got %b %h want 100 0", {req_ready, dmem_req, split}, rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || rdata !== 32'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstw1_stray%0d: got %b %h %b want 0 0 1", i, resp_valid, rdata, req_ready); end
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_store_aligned;
        test_store_split;
        test_load_split_stall;
        test_load_half;
        test_back_to_back;
        test_reset_wait1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
